// File: rtl/sprite_cmd_dispatch.sv
// Sprite command dispatcher: CPU writes go into a FIFO and drain one word per cycle onto cmd_out, always aimed at the back buffer.
// Latency: a word pushed into an empty FIFO in DRAIN appears on cmd_out one cycle after the push edge; status reads return the next cycle.
// Backpressure: none upstream. A push to a full FIFO is dropped and sets sticky ovf, unless a pop happens in that same cycle.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   chipselect/write/read  Avalon slave strobes; address 0=push, 1=commit, 2=status/clear-ovf
//   writedata/readdata     32-bit Avalon data; readdata is registered
//   hcount, vcount         VGA raster position; only vcount is used (start of vblank)
//   cmd_out                command word broadcast to every display component, 0 when idle
//   front_buf              index of the buffer currently being displayed

module sprite_cmd_dispatch #(
    parameter int FIFO_DEPTH  = 16,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        front_buf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_DRAIN   = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            commit_pend_q, commit_pend_d;
    logic            ovf_q, ovf_d;
    logic            front_buf_q, front_buf_d;
    logic [31:0]     cmd_out_q, cmd_out_d;
    logic [31:0]     readdata_q, readdata_d;
    logic [9:0]      vcount_prev_q, vcount_prev_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            wr_en, rd_en;
    logic            push_req, commit_req, ovf_clr;
    logic            fifo_empty, fifo_full;
    logic            pop, push, drop;
    logic            vb_rise;
    logic [31:0]     head;
    logic [31:0]     status;

    // hcount is part of the shared raster bus but carries no information here.
    logic            unused_hcount;
    assign unused_hcount = ^hcount;

    assign wr_en      = chipselect && write;
    assign rd_en      = chipselect && read;
    assign push_req   = wr_en && (address == 2'd0);
    assign commit_req = wr_en && (address == 2'd1);
    assign ovf_clr    = wr_en && (address == 2'd2);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (state_q == ST_DRAIN) && !fifo_empty;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;

    // Only the first line of vblank triggers, so holding vcount at the line cannot swap twice.
    assign vb_rise    = (vcount == 10'(VBLANK_LINE)) && (vcount_prev_q != 10'(VBLANK_LINE));

    assign head       = mem_q[rd_ptr_q];
    assign status     = {ovf_q, commit_pend_q, front_buf_q, state_q, 27'(count_q)};

    always_comb begin
        state_d       = state_q;
        commit_pend_d = commit_pend_q;
        front_buf_d   = front_buf_q;
        cmd_out_d     = 32'h0;
        ovf_d         = ovf_q;
        readdata_d    = 32'h0;
        vcount_prev_d = vcount;
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (commit_req) begin
            commit_pend_d = 1'b1;
        end

        // Clear first so an overflow in the same cycle wins.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        if (rd_en && (address == 2'd2)) begin
            readdata_d = status;
        end

        case (state_q)
            ST_DRAIN: begin
                if (pop) begin
                    // Bit 13 always selects the back buffer.
                    cmd_out_d = {head[31:14], ~front_buf_q, head[12:0]};
                end
                // Leave once the words queued before the commit are gone. A word
                // pushed in this same cycle stays held for the new back buffer.
                if (commit_pend_q && (count_q <= CW'(1))) begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (vb_rise) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                cmd_out_d     = {6'd0, 5'd0, 4'b1111, 3'd0, ~front_buf_q, 13'd0};
                front_buf_d   = ~front_buf_q;
                commit_pend_d = 1'b0;
                state_d       = ST_DRAIN;
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_DRAIN;
            commit_pend_q <= 1'b0;
            ovf_q         <= 1'b0;
            front_buf_q   <= 1'b0;
            cmd_out_q     <= 32'h0;
            readdata_q    <= 32'h0;
            vcount_prev_q <= 10'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            commit_pend_q <= commit_pend_d;
            ovf_q         <= ovf_d;
            front_buf_q   <= front_buf_d;
            cmd_out_q     <= cmd_out_d;
            readdata_q    <= readdata_d;
            vcount_prev_q <= vcount_prev_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= writedata;
        end
    end

    assign cmd_out   = cmd_out_q;
    assign readdata  = readdata_q;
    assign front_buf = front_buf_q;

endmodule

// File: tb/tb_sprite_cmd_dispatch.sv
module tb_sprite_cmd_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        front_buf;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_q[$];
    logic        rd_flag = 1'b0;

    sprite_cmd_dispatch #(.FIFO_DEPTH(16), .VBLANK_LINE(480)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .hcount     (hcount),
        .vcount     (vcount),
        .cmd_out    (cmd_out),
        .front_buf  (front_buf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, inputs change just after the rising edge.
    always @(negedge clk) begin
        if (rd_flag) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL readdata: got %h with no read expectation queued", readdata);
            end else begin
                check("readdata", readdata, rd_q.pop_front());
            end
        end
        rd_flag = chipselect && read;
        if (cmd_out !== 32'h0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_out: got %h, required idle 00000000", cmd_out);
            end else begin
                check("cmd_out", cmd_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writedata  = 32'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] req);
        rd_q.push_back(req);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        idle();
    endtask

    task automatic vblank();
        vcount = 10'd479;
        tick();
        vcount = 10'd480;
        tick();
    endtask

    initial begin
        logic [31:0] w;
        reset  = 1'b1;
        hcount = 10'd0;
        vcount = 10'd0;
        idle();

        // Reset held for 3 cycles.
        ticks(3);
        reset = 1'b0;
        check("reset cmd_out", cmd_out, 32'h0);
        check("reset front_buf", {31'd0, front_buf}, 32'h0);
        rd(2'd2, 32'h0000_0000);
        ticks(2);

        // Two back-to-back pushes, bit 13 forced to back buffer 1.
        exp_q.push_back(32'h2820_2801);
        exp_q.push_back(32'h2820_6005);
        wr(2'd0, 32'h2820_0801);
        wr(2'd0, 32'h2820_4005);
        ticks(4);

        // Commit, a held push, then vblank: swap word, then the held word aimed at new back buffer 0.
        exp_q.push_back(32'h001E_2000);
        exp_q.push_back(32'h2820_0801);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h2820_0801);
        ticks(3);
        vblank();
        tick();
        check("front_buf after swap", {31'd0, front_buf}, 32'h1);
        ticks(3);

        // Commit on empty FIFO then 17 pushes while waiting (vcount held at 480, no retrigger).
        wr(2'd1, 32'h0);
        for (int i = 0; i < 17; i++) begin
            w = 32'h0800_0000 | 32'(i + 1);
            if (i < 16) exp_q.push_back(w | 32'h0000_2000);
            wr(2'd0, w);
        end
        rd(2'd2, 32'hE800_0010);
        rd(2'd0, 32'h0000_0000);
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h6800_0010);
        // Swap to front 0, then a push on the first drain cycle with the FIFO still full.
        exp_q.push_front(32'h001E_0000);
        exp_q.push_back(32'h0C00_2055);
        vblank();
        tick();
        wr(2'd0, 32'h0C00_0055);
        rd(2'd2, 32'h0000_0010);
        ticks(20);
        vcount = 10'd0;

        // Commit with nothing queued: swap to front 1 only.
        exp_q.push_back(32'h001E_2000);
        wr(2'd1, 32'h0);
        ticks(2);
        vblank();
        ticks(3);
        vcount = 10'd0;
        tick();

        // Reset while waiting for vblank with 5 words held: no swap, nothing drains.
        wr(2'd1, 32'h0);
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h1000_0000 | 32'(i + 1));
        rd(2'd2, 32'h6800_0005);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        vblank();
        ticks(4);
        check("front_buf after reset", {31'd0, front_buf}, 32'h0);
        rd(2'd2, 32'h0000_0000);
        ticks(3);

        check("cmd_out expectations left", 32'(exp_q.size()), 32'h0);
        check("readdata expectations left", 32'(rd_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
